// File: rtl/mcpu_pkg.sv
// Shared definitions for the memory-mapped I/O memory model: FSM encoding,
// wait-counter width and the address legality rule.
package mcpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mio_state_e;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned CPU_ADDR_W = 32;

    // Illegal when misaligned or when any bit above the word index is set.
    function automatic logic addr_is_bad(input logic [CPU_ADDR_W-1:0] addr,
                                         input int unsigned word_bits);
        logic [CPU_ADDR_W-1:0] upper;
        upper = addr >> (word_bits + 2);
        return (addr[1:0] != 2'b00) || (upper != '0);
    endfunction

endpackage

// File: rtl/mio_mem_model_if.sv
// CPU-side bus and program-preload signals of the memory model.
interface mio_mem_model_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              CPU_MIO;
    logic              mem_w;
    logic [31:0]       Addr_out;
    logic [DATA_W-1:0] Data_out;
    logic [DATA_W-1:0] Data_in;
    logic              MIO_ready;
    logic              addr_err;
    logic              busy;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;

    modport slave (
        input  CPU_MIO, mem_w, Addr_out, Data_out, ld_en, ld_addr, ld_data,
        output Data_in, MIO_ready, addr_err, busy
    );

    modport master (
        output CPU_MIO, mem_w, Addr_out, Data_out, ld_en, ld_addr, ld_data,
        input  Data_in, MIO_ready, addr_err, busy
    );

endinterface

// File: rtl/mio_sram.sv
// Word-wide storage with one synchronous write port and one synchronous,
// enable-held read port; contents survive reset, the read register does not.
module mio_sram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // clr_i returns zero for a rejected read instead of stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mio_mem_model.sv
// Wait-stated CPU memory model: IDLE accepts a request or a preload, WAIT
// burns WAIT_CYCLES, RESP pulses MIO_ready and commits writes on exit.
module mio_mem_model
    import mcpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    mio_mem_model_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    mio_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         word_q, word_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  req_bad;
    logic                  rd_bad, rd_we, rd_go;
    logic                  sram_we, sram_re, sram_clr;
    logic [AW-1:0]         sram_waddr, sram_raddr;
    logic [DATA_W-1:0]     sram_wdata;

    assign accept  = (state_q == ST_IDLE) && !bus.ld_en && bus.CPU_MIO;
    assign req_bad = addr_is_bad(bus.Addr_out, AW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = bus.Addr_out[AW+1:2];
                    wdata_d = bus.Data_out;
                    we_d    = bus.mem_w;
                    err_d   = req_bad;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The read is launched on the edge entering RESP, so Data_in only moves
    // when a read completes; with no wait states that edge is the accepting one.
    always_comb begin
        bus.MIO_ready = (state_q == ST_RESP);
        bus.addr_err  = (state_q == ST_RESP) && err_q;
        bus.busy      = (state_q != ST_IDLE);

        rd_bad     = (state_q == ST_IDLE) ? req_bad : err_q;
        rd_we      = (state_q == ST_IDLE) ? bus.mem_w : we_q;
        sram_raddr = (state_q == ST_IDLE) ? bus.Addr_out[AW+1:2] : word_q;
        rd_go      = (state_d == ST_RESP) && (state_q != ST_RESP) && !rd_we;
        sram_re    = rd_go && !rd_bad;
        sram_clr   = rd_go && rd_bad;

        sram_we    = 1'b0;
        sram_waddr = word_q;
        sram_wdata = wdata_q;
        if ((state_q == ST_RESP) && we_q && !err_q) begin
            sram_we = 1'b1;
        end else if ((state_q == ST_IDLE) && bus.ld_en) begin
            sram_we    = 1'b1;
            sram_waddr = bus.ld_addr;
            sram_wdata = bus.ld_data;
        end
    end

    mio_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (sram_we),
        .waddr_i (sram_waddr),
        .wdata_i (sram_wdata),
        .re_i    (sram_re),
        .clr_i   (sram_clr),
        .raddr_i (sram_raddr),
        .rdata_o (bus.Data_in)
    );

endmodule
